mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-requester arbiter and sequencer for the processor's single data/instruction memory port. Requester 0 is datapath load/store, requester 1 is instruction fetch, requester 2 is an external/peripheral master. The block grants one access at a time and drives the synchronous block-RAM port. For reads, it waits out the RAM read latency and returns the read data with a one-cycle valid strobe to the winning requester. It sits between the processor's integration level and the memory module, replacing direct wiring of `addr1`/`w1`/`data1` to memory.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `RD_LAT`, 1, RAM read latency in cycles (legal 1..4)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `CLK`  in  1  clock, all state on rising edge
- `CLR`  in  1  synchronous active-high reset
- `req`  in  3  access request, bit i = requester i
- `we`  in  3  1 = write, 0 = read, per requester
- `addr0`, `addr1`, `addr2`  in  AW each  request address per requester
- `wdata0`, `wdata1`, `wdata2`  in  DW each  write data per requester
- `gnt`  out  3  one-hot, one-cycle grant pulse; marks the cycle the access is on the RAM port
- `rvalid`  out  3  one-hot, one-cycle read-data-valid strobe
- `rdata`  out  DW  read data, equals `mem_dout`, meaningful only while any `rvalid` is high
- `mem_addr`  out  AW  RAM address (registered)
- `mem_din`  out  DW  RAM write data (registered)
- `mem_we`  out  1  RAM write enable (registered)
- `mem_dout`  in  DW  RAM read data
- `busy`  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE
  - ISSUE: one cycle; `gnt` and RAM signals valid.
  - WAIT: RD_LAT−1 cycles, reads only.
  - RESP: one cycle; `rvalid` high.
- An arbitration edge is any rising edge where the current state is IDLE, RESP, or ISSUE carrying a write.
- At an arbitration edge with any `req` bit high:
  - The winner's `we`/`addr`/`wdata` are latched into `mem_we`/`mem_addr`/`mem_din`.
  - `gnt[winner]` is set.
  - The state goes to ISSUE.
- With no request at an arbitration edge, the state goes to IDLE.
- ISSUE with a write: `mem_we`=1 for exactly that cycle. The next state is decided by arbitration, so back-to-back writes run at 1 per cycle.
- ISSUE with a read: the state goes to WAIT, or directly to RESP when RD_LAT=1.
- WAIT counts down RD_LAT−1 cycles, then goes to RESP.
- RESP: `rvalid[owner]`=1 and `rdata`=`mem_dout`. The owner is the requester granted in the preceding ISSUE.
- Default priority is fixed, 0 > 1 > 2.
- Requester protocol: hold `req`, `we`, `addr`, `wdata` stable until `gnt` is seen, then drop `req` in the `gnt` cycle unless another access is wanted.
  - `req` held high through `gnt` is a new request and is eligible at the next arbitration edge.
  - `req` withdrawn before `gnt` is a protocol violation. An access already latched still completes.
- `mem_we` is 0 in every cycle other than a write ISSUE. `mem_addr`/`mem_din` hold their last values outside ISSUE.
- Reset values: state IDLE; `gnt`=0, `rvalid`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `busy`=0; round-robin pointer = 2, so requester 0 is searched first.
- `CLR` mid-operation aborts any in-flight read with no `rvalid` issued. A write ISSUE whose edge coincides with `CLR` still completes in RAM, because the RAM captures it on the same edge.

## Timing
- Write: `req` high in cycle 0 (IDLE). `gnt` and `mem_we` high in cycle 1. RAM written at the end of cycle 1.
- Read: `req` in cycle 0, `gnt` in cycle 1, `rvalid` in cycle 1+RD_LAT.
- Worst-case read occupancy is 1+RD_LAT cycles. The next grant is issued at the RESP edge, so there are no idle cycles between reads.
- With fixed priority, a continuously requesting requester 0 starves requesters 1 and 2. This is by design: the datapath owns the port.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The search starts at (last winner + 1) mod 3.
  - The pointer updates on every grant.
  - Any requester held high is granted within 3 grants.
- Undefined: fixed priority 0 > 1 > 2. The pointer register is absent.

## Test plan
- Reset, then single write (requester 1, addr 0x0040, data 0xBEEF) → `gnt`=3'b010 and `mem_we`=1 in cycle 1 only; a later read of 0x0040 returns 0xBEEF.
- RD_LAT=1, RD_LAT=3: requester 0 read of preloaded 0x1234 at 0x0007 → `rvalid`=3'b001 exactly 1 and 3 cycles after `gnt`, `rdata`=0x1234, `busy` high throughout.
- All three `req` high simultaneously with fixed priority → grant order 0,1,2. With `MEM_ARB_ROUND_ROBIN_EN`, requesters 0 and 2 held high continuously → grants alternate 0,2,0,2.
- Four back-to-back writes from requester 2 → four consecutive `gnt` cycles, `mem_we` high four cycles, no gaps.
- `CLR` asserted during WAIT (RD_LAT=3) → next cycle all outputs at reset values, no `rvalid` ever issued for that read.
- Read from requester 0 followed by a read from requester 1 pending during RESP → `gnt[1]` in the cycle after RESP, no IDLE cycle between.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters plus RAM (the surrounding system).
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          busy;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_dout,
        output gnt, rvalid, rdata, mem_addr, mem_din, mem_we, busy
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_dout,
        input  gnt, rvalid, rdata, mem_addr, mem_din, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter/sequencer for the single synchronous block-RAM port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority 0 > 1 > 2.
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input logic               CLK,
    input logic               CLR,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // WAIT lasts RD_LAT-1 cycles, so the counter is loaded with RD_LAT-2 and exits at zero.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t        state_q;
    logic [2:0]    gnt_q;
    logic [2:0]    rvalid_q;
    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [DW-1:0] memDin_q;
    logic [1:0]    owner_q;
    logic [1:0]    waitCnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0]    rrPtr_q;
`endif

    logic          anyReq;
    logic          arbEdge;
    logic [1:0]    owner_d;
    logic [2:0]    gnt_d;
    logic          memWe_d;
    logic [AW-1:0] memAddr_d;
    logic [DW-1:0] memDin_d;
    logic [2:0]    ownerOneHot;

    assign anyReq      = |bus.req;
    assign arbEdge     = (state_q == IDLE) || (state_q == RESP) || ((state_q == ISSUE) && memWe_q);
    assign ownerOneHot = 3'b001 << owner_q;

    always_comb begin
        owner_d = 2'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Search starts one past the last winner.
        case (rrPtr_q)
            2'd0: begin
                if (bus.req[1])      owner_d = 2'd1;
                else if (bus.req[2]) owner_d = 2'd2;
                else                 owner_d = 2'd0;
            end
            2'd1: begin
                if (bus.req[2])      owner_d = 2'd2;
                else if (bus.req[0]) owner_d = 2'd0;
                else                 owner_d = 2'd1;
            end
            default: begin
                if (bus.req[0])      owner_d = 2'd0;
                else if (bus.req[1]) owner_d = 2'd1;
                else                 owner_d = 2'd2;
            end
        endcase
`else
        if (bus.req[0])      owner_d = 2'd0;
        else if (bus.req[1]) owner_d = 2'd1;
        else                 owner_d = 2'd2;
`endif
    end

    always_comb begin
        gnt_d     = 3'b001 << owner_d;
        memWe_d   = bus.we[0];
        memAddr_d = bus.addr0;
        memDin_d  = bus.wdata0;
        case (owner_d)
            2'd1: begin
                memWe_d   = bus.we[1];
                memAddr_d = bus.addr1;
                memDin_d  = bus.wdata1;
            end
            2'd2: begin
                memWe_d   = bus.we[2];
                memAddr_d = bus.addr2;
                memDin_d  = bus.wdata2;
            end
            default: begin
                memWe_d   = bus.we[0];
                memAddr_d = bus.addr0;
                memDin_d  = bus.wdata0;
            end
        endcase
    end

    // Pulses (gnt, rvalid, mem_we) default low; address/data hold outside ISSUE.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            rvalid_q  <= 3'b000;
            memWe_q   <= 1'b0;
            memAddr_q <= '0;
            memDin_q  <= '0;
            owner_q   <= 2'd0;
            waitCnt_q <= 2'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rrPtr_q   <= 2'd2;
`endif
        end else begin
            gnt_q    <= 3'b000;
            rvalid_q <= 3'b000;
            memWe_q  <= 1'b0;
            if (arbEdge) begin
                if (anyReq) begin
                    state_q   <= ISSUE;
                    gnt_q     <= gnt_d;
                    memWe_q   <= memWe_d;
                    memAddr_q <= memAddr_d;
                    memDin_q  <= memDin_d;
                    owner_q   <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rrPtr_q   <= owner_d;
`endif
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    ISSUE: begin
                        if (RD_LAT == 1) begin
                            state_q  <= RESP;
                            rvalid_q <= ownerOneHot;
                        end else begin
                            state_q   <= WAIT;
                            waitCnt_q <= WAIT_INIT;
                        end
                    end
                    WAIT: begin
                        if (waitCnt_q == 2'd0) begin
                            state_q  <= RESP;
                            rvalid_q <= ownerOneHot;
                        end else begin
                            waitCnt_q <= waitCnt_q - 2'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = bus.mem_dout;
    assign bus.mem_addr = memAddr_q;
    assign bus.mem_din  = memDin_q;
    assign bus.mem_we   = memWe_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level port-occupancy model, with a small block-RAM model on the memory side.
module tb_mem_port_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;

    logic CLK = 1'b0;
    logic CLR;
    logic initRam;

    logic [2:0]    reqV;
    logic [2:0]    weV;
    logic [AW-1:0] addrV  [3];
    logic [DW-1:0] wdataV [3];

    int totalChecks = 0;
    int badChecks   = 0;
    logic checkEn   = 1'b0;

    // Reference model state: cycle-level occupancy of the single port.
    int            cycleNo    = 0;
    int            freeFrom   = 0;
    int            lastBusy   = -1;
    int            rrLast     = 2;
    int            grantedIdx = -1;
    logic          pendValid  = 1'b0;
    int            pendCycle  = 0;
    int            pendOwner  = 0;
    logic [DW-1:0] pendData   = '0;
    logic [DW-1:0] refMem [0:127];

    logic [2:0]    expGnt    = 3'b000;
    logic [2:0]    expRvalid = 3'b000;
    logic          expWe     = 1'b0;
    logic          expBusy   = 1'b0;
    logic [AW-1:0] expAddr   = '0;
    logic [DW-1:0] expDin    = '0;
    logic [DW-1:0] expRdata  = '0;

    logic [DW-1:0] ram    [0:127];
    logic [DW-1:0] rdPipe [0:RD_LAT-1];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    assign bus.req    = reqV;
    assign bus.we     = weV;
    assign bus.addr0  = addrV[0];
    assign bus.addr1  = addrV[1];
    assign bus.addr2  = addrV[2];
    assign bus.wdata0 = wdataV[0];
    assign bus.wdata1 = wdataV[1];
    assign bus.wdata2 = wdataV[2];
    assign bus.mem_dout = rdPipe[RD_LAT-1];

    // Synchronous RAM with RD_LAT cycles from address to data.
    always @(posedge CLK) begin
        if (initRam) begin
            for (int k = 0; k < 128; k++) ram[k] <= '0;
            ram[7] <= 16'h1234;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[6:0]] <= bus.mem_din;
        end
        rdPipe[0] <= ram[bus.mem_addr[6:0]];
        for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", tag, actual, expected, cycleNo);
        end
    endtask

    function automatic int pickWinner(input logic [2:0] r, input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
`else
        for (int k = 0; k < 3; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    // A write holds the port for its grant cycle; a read holds it for 1+RD_LAT
    // cycles and returns data in the last one. Arbitration happens at the first
    // edge after the port frees up.
    task automatic modelEdge();
        int w;
        cycleNo++;
        grantedIdx = -1;
        expGnt     = 3'b000;
        expWe      = 1'b0;
        expRvalid  = 3'b000;
        if (CLR) begin
            expAddr   = '0;
            expDin    = '0;
            pendValid = 1'b0;
            lastBusy  = cycleNo - 1;
            freeFrom  = cycleNo + 1;
            rrLast    = 2;
        end else begin
            if (pendValid && pendCycle == cycleNo) begin
                expRvalid = 3'b001 << pendOwner;
                expRdata  = pendData;
                pendValid = 1'b0;
            end
            if (cycleNo >= freeFrom && reqV != 3'b000) begin
                w          = pickWinner(reqV, rrLast);
                grantedIdx = w;
                rrLast     = w;
                expGnt     = 3'b001 << w;
                expAddr    = addrV[w];
                expDin     = wdataV[w];
                if (weV[w]) begin
                    expWe = 1'b1;
                    refMem[addrV[w][6:0]] = wdataV[w];
                    lastBusy = cycleNo;
                    freeFrom = cycleNo + 1;
                end else begin
                    pendValid = 1'b1;
                    pendOwner = w;
                    pendData  = refMem[addrV[w][6:0]];
                    pendCycle = cycleNo + RD_LAT;
                    lastBusy  = cycleNo + RD_LAT;
                    freeFrom  = cycleNo + RD_LAT + 1;
                end
            end
        end
        expBusy = (cycleNo <= lastBusy);
    endtask

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("gnt",      32'(bus.gnt),      32'(expGnt));
            checkOutput("rvalid",   32'(bus.rvalid),   32'(expRvalid));
            checkOutput("mem_we",   32'(bus.mem_we),   32'(expWe));
            checkOutput("busy",     32'(bus.busy),     32'(expBusy));
            checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expAddr));
            checkOutput("mem_din",  32'(bus.mem_din),  32'(expDin));
            if (expRvalid != 3'b000) checkOutput("rdata", 32'(bus.rdata), 32'(expRdata));
        end
    end

    // One clock: model the edge, then the granted requester drops req in its gnt cycle.
    task automatic tick();
        @(posedge CLK);
        modelEdge();
        #1;
        if (grantedIdx >= 0) reqV[grantedIdx] = 1'b0;
    endtask

    task automatic applyStimulus(input int who, input logic isWrite, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqV[who]   = 1'b1;
        weV[who]    = isWrite;
        addrV[who]  = a;
        wdataV[who] = d;
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((reqV != 3'b000 || cycleNo <= lastBusy) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("drainTimeout", 32'(reqV != 3'b000 || cycleNo <= lastBusy), 32'd0);
    endtask

    // Direct read with constant expectations on data and gnt-to-rvalid latency.
    task automatic readAndExpect(input int who, input logic [AW-1:0] a, input logic [DW-1:0] expData, input string tag);
        int            seenAt  = 0;
        int            grantAt = 0;
        logic [DW-1:0] got     = '0;
        applyStimulus(who, 1'b0, a, '0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            @(negedge CLK);
            if (bus.gnt[who] && grantAt == 0) grantAt = n;
            if (bus.rvalid[who] && seenAt == 0) begin
                seenAt = n;
                got    = bus.rdata;
            end
        end
        checkOutput({tag, "GntCycle"}, 32'(grantAt), 32'd1);
        checkOutput({tag, "RvalidCycle"}, 32'(seenAt), 32'(1 + RD_LAT));
        checkOutput({tag, "Data"}, 32'(got), 32'(expData));
    endtask

    initial begin
        for (int k = 0; k < 128; k++) refMem[k] = '0;
        refMem[7] = 16'h1234;
        reqV = 3'b000;
        weV  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addrV[i]  = '0;
            wdataV[i] = '0;
        end
        CLR     = 1'b1;
        initRam = 1'b1;
        tick();
        checkEn = 1'b1;
        tick();
        CLR     = 1'b0;
        initRam = 1'b0;
        tick();

        applyStimulus(1, 1'b1, 16'h0040, 16'hBEEF);
        drain(10);
        readAndExpect(0, 16'h0040, 16'hBEEF, "beef");
        readAndExpect(0, 16'h0007, 16'h1234, "pre");

        applyStimulus(0, 1'b1, 16'h0001, 16'h1111);
        applyStimulus(1, 1'b1, 16'h0002, 16'h2222);
        applyStimulus(2, 1'b1, 16'h0003, 16'h3333);
        drain(20);

        applyStimulus(0, 1'b1, 16'h0004, DW'($urandom));
        applyStimulus(2, 1'b1, 16'h0005, DW'($urandom));
        for (int n = 0; n < 8; n++) begin
            tick();
            if (!reqV[0]) applyStimulus(0, 1'b1, 16'h0004, DW'($urandom));
            if (!reqV[2]) applyStimulus(2, 1'b1, 16'h0005, DW'($urandom));
        end
        drain(30);

        applyStimulus(2, 1'b1, 16'h0008, DW'($urandom));
        for (int n = 0; n < 4; n++) begin
            tick();
            if (n < 3) applyStimulus(2, 1'b1, AW'(9 + n), DW'($urandom));
        end
        drain(10);

        applyStimulus(0, 1'b0, 16'h0007, '0);
        tick();
        tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        for (int n = 0; n < 6; n++) tick();

        applyStimulus(0, 1'b0, 16'h0040, '0);
        applyStimulus(1, 1'b0, 16'h0007, '0);
        drain(20);

        for (int n = 0; n < 1500; n++) begin
            CLR = ($urandom_range(79) == 0);
            tick();
            CLR = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!reqV[i] && $urandom_range(2) == 0)
                    applyStimulus(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
            end
        end
        drain(200);
        tick();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
